// File: rtl/hdmi_phy_lane_ctrl.sv
// Pixel-clock lane conditioner between the TMDS encoders and the 10:1 serializers:
// per-channel skew delay, optional bit reversal, power-up idle words and test patterns.
module hdmi_phy_lane_ctrl #(
  parameter int                 CHANNELS       = 3,
  parameter int                 WORD_W         = 10,
  parameter int                 MAX_SKEW       = 4,
  parameter bit                 BIT_REVERSE    = 1'b1,
  parameter int                 STARTUP_CYCLES = 64,
  parameter logic [WORD_W-1:0]  IDLE_WORD      = 10'b1101010100,
  parameter logic [WORD_W-1:0]  CLK_WORD       = 10'b1111100000,
  localparam int                SKEW_W         = $clog2(MAX_SKEW + 1)
) (
  input  logic                         I_pixel_clk,
  input  logic                         I_rst,
  input  logic [CHANNELS*WORD_W-1:0]   I_data,
  input  logic [1:0]                   I_mode,
  input  logic [WORD_W-1:0]            I_pattern,
  input  logic [CHANNELS*SKEW_W-1:0]   I_skew,
  output logic [CHANNELS*WORD_W-1:0]   O_data,
  output logic [WORD_W-1:0]            O_clk_word,
  output logic                         O_ready
);

  localparam int CNT_W = $clog2(STARTUP_CYCLES + 2);

  localparam logic [1:0] MODE_NORMAL  = 2'd0;
  localparam logic [1:0] MODE_PRBS    = 2'd1;
  localparam logic [1:0] MODE_PATTERN = 2'd2;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_STARTUP,
    ST_RUN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  logic [WORD_W-1:0]  dline [CHANNELS][MAX_SKEW+1];
  logic [WORD_W-1:0]  tap_word [CHANNELS];

  logic [1:0]         mode_r;
  logic [WORD_W-1:0]  pattern_r;
  logic [6:0]         lfsr;
  logic [6:0]         gen_state;
  logic [WORD_W-1:0]  gen_word;
  logic [WORD_W-1:0]  prbs_word;

  logic [CHANNELS*WORD_W-1:0] run_data;
  logic [CHANNELS*WORD_W-1:0] idle_data;

  function automatic logic [WORD_W-1:0] orient(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    if (BIT_REVERSE) begin
      for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
    end
    return r;
  endfunction

  always_ff @(posedge I_pixel_clk) begin
    if (I_rst) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the number of idle words already emitted while in STARTUP
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_RESET: begin
        state_next = (STARTUP_CYCLES == 0) ? ST_RUN : ST_STARTUP;
        cnt_next   = CNT_W'(1);
      end
      ST_STARTUP: begin
        if (cnt >= CNT_W'(STARTUP_CYCLES)) state_next = ST_RUN;
        else                               cnt_next   = cnt + CNT_W'(1);
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge I_pixel_clk) begin
    if (I_rst) begin
      for (int k = 0; k < CHANNELS; k++)
        for (int i = 0; i <= MAX_SKEW; i++) dline[k][i] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        dline[k][0] <= I_data[k*WORD_W +: WORD_W];
        for (int i = 1; i <= MAX_SKEW; i++) dline[k][i] <= dline[k][i-1];
      end
    end
  end

  // Mux chain gives min(skew, MAX_SKEW) without a variable index
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      tap_word[k] = dline[k][0];
      for (int i = 1; i <= MAX_SKEW; i++)
        if (int'(I_skew[k*SKEW_W +: SKEW_W]) >= i) tap_word[k] = dline[k][i];
    end
  end

  // Reseed on mode-1 entry and outside RUN so PRBS always starts fresh at RUN
  always_comb begin
    gen_state = lfsr;
    gen_word  = '0;
    if (I_mode == MODE_PRBS && (mode_r != MODE_PRBS || state_next != ST_RUN))
      gen_state = 7'h7F;
    for (int j = 0; j < WORD_W; j++) begin
      gen_word[j] = gen_state[6] ^ gen_state[5];
      gen_state   = {gen_state[5:0], gen_word[j]};
    end
  end

  always_ff @(posedge I_pixel_clk) begin
    if (I_rst) begin
      mode_r    <= MODE_NORMAL;
      pattern_r <= '0;
      lfsr      <= 7'h7F;
      prbs_word <= '0;
    end else begin
      mode_r    <= I_mode;
      pattern_r <= I_pattern;
      if (I_mode == MODE_PRBS) begin
        lfsr      <= gen_state;
        prbs_word <= gen_word;
      end
    end
  end

  always_comb begin
    run_data  = '0;
    idle_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idle_data[k*WORD_W +: WORD_W] = orient(IDLE_WORD);
      case (mode_r)
        MODE_NORMAL:  run_data[k*WORD_W +: WORD_W] = orient(tap_word[k]);
        MODE_PRBS:    run_data[k*WORD_W +: WORD_W] = orient(prbs_word);
        MODE_PATTERN: run_data[k*WORD_W +: WORD_W] = orient(pattern_r);
        default:      run_data[k*WORD_W +: WORD_W] = orient(CLK_WORD);
      endcase
    end
  end

  always_ff @(posedge I_pixel_clk) begin
    if (I_rst) begin
      O_data     <= '0;
      O_clk_word <= '0;
      O_ready    <= 1'b0;
    end else begin
      O_clk_word <= orient(CLK_WORD);
      O_ready    <= (state_next == ST_RUN);
      O_data     <= (state_next == ST_RUN) ? run_data : idle_data;
    end
  end

endmodule
